div_share_arbiter: RTL and testbench
====================================

Name: div_share_arbiter

Overview:
- Shares one DivisorUnit instance between NUM_REQ requesters (e.g. integer pipe and CSR/debug path).
- Per-requester valid/ready request and response handshakes; round-robin arbitration.
- Sequences the divider: one-cycle valid pulse, then waits for the res_ready rising edge.
- Divide-by-zero is answered locally without starting the divider.

Parameters:
- PARALLELISM, 32, operand/result width; must match the DivisorUnit instance.
- NUM_REQ, 2, number of requesters (2..8).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- req_usigned  in  NUM_REQ  1 = unsigned divide
- req_dividend  in  NUM_REQ*PARALLELISM  packed; requester i at [i*P +: P]
- req_divisor  in  NUM_REQ*PARALLELISM  packed, same layout
- resp_valid  out  NUM_REQ  result valid for the owner requester (one-hot or zero)
- resp_ready  in  NUM_REQ  requester consumes the result
- resp_quotient  out  PARALLELISM  shared result bus
- resp_reminder  out  PARALLELISM  shared result bus
- div_valid  out  1  start pulse to DivisorUnit
- div_usigned  out  1  to DivisorUnit
- div_dividend  out  PARALLELISM  to DivisorUnit
- div_divisor  out  PARALLELISM  to DivisorUnit
- div_quotient  in  PARALLELISM  from DivisorUnit
- div_reminder  in  PARALLELISM  from DivisorUnit
- div_res_ready  in  1  from DivisorUnit; completion is its rising edge
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=1, asynchronous):
  - State IDLE; rr pointer = 0; owner = 0; res_ready_q = 0.
  - All outputs 0, including operand and result registers.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, searching from rr pointer upward with wrap.
  - req_ready[grant]=1 combinationally in the same cycle; other bits 0.
  - On transfer, latch usigned, dividend, divisor and owner=grant.
  - Latched divisor != 0 -> ISSUE.
  - Latched divisor == 0 -> RESP next cycle with quotient = all ones, reminder = dividend (both signed and unsigned); divider untouched.
- ISSUE: div_valid=1 for exactly this one cycle; div_* operands driven from latches, held stable through WAIT; -> WAIT.
- WAIT:
  - res_ready_q <= div_res_ready every cycle in all states.
  - Completion = div_res_ready & ~res_ready_q, honoured only in WAIT.
  - On completion, capture div_quotient/div_reminder into result registers -> RESP.
  - Rising edges in other states are ignored.
  - No timeout.
- RESP:
  - resp_valid[owner]=1; result bus held stable.
  - Exit when resp_ready[owner]=1: -> IDLE; rr pointer = (owner+1) mod NUM_REQ.
  - resp_ready bits of non-owners are ignored.
- No new request is accepted before RESP exits; req_ready=0 outside IDLE.
- Latency, request accept cycle T to resp_valid, with a divider taking D cycles from valid to res_ready rise:
  - Nonzero divisor: T+2+D.
  - Zero divisor: T+1.
- Requester rules:
  - Operands must be stable while req_valid=1 and ready=0.
  - Deasserting req_valid before acceptance is allowed (withdraw).
- Reset mid-operation:
  - Abort to IDLE; result is lost; no resp_valid.
  - The divider is not reset by this block. A late res_ready edge is dropped because it arrives outside WAIT.
  - The next issue must wait for div_res_ready=0. ISSUE is entered only when div_res_ready=0; otherwise the FSM stays in IDLE, not granting.
- rr pointer wraps NUM_REQ-1 -> 0. A lone requester is always granted regardless of pointer.

Test Plan:
- Unsigned single op: req 0, usigned=1, dividend=100, divisor=7 -> one req_ready pulse, one div_valid pulse; resp_valid[0] with quotient=14, reminder=2; busy low after resp_ready.
- Signed: req 1, usigned=0, dividend=0xFFFFFFF9 (-7), divisor=2 -> quotient=0xFFFFFFFD, reminder=0xFFFFFFFF (truncating semantics).
- Round robin: both valid continuously from reset with distinct ops -> grant order 0,1,0,1; each response goes only to its owner's resp_valid bit.
- Divide by zero: dividend=0x1234, divisor=0 -> resp_valid one cycle after accept; quotient=0xFFFFFFFF, reminder=0x1234; div_valid never asserted.
- Backpressure: hold resp_ready low 10 cycles in RESP -> result bus stable, req_ready stays 0 despite other req_valid; release -> IDLE, other requester granted next.
- Reset in WAIT: assert rst_n mid-divide -> all outputs 0 asynchronously; the later res_ready edge produces no resp_valid; a new request then completes correctly.

Source files
------------

// File: rtl/div_share_arbiter.sv
// Round-robin front end that shares one DivisorUnit between NUM_REQ requesters.
// rst_n is asynchronous and active-high; the name is kept for compatibility with the existing codebase.
module div_share_arbiter #(
  parameter int PARALLELISM = 32,
  parameter int NUM_REQ     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_usigned,
  input  logic [NUM_REQ*PARALLELISM-1:0] req_dividend,
  input  logic [NUM_REQ*PARALLELISM-1:0] req_divisor,
  output logic [NUM_REQ-1:0]             resp_valid,
  input  logic [NUM_REQ-1:0]             resp_ready,
  output logic [PARALLELISM-1:0]         resp_quotient,
  output logic [PARALLELISM-1:0]         resp_reminder,
  output logic                           div_valid,
  output logic                           div_usigned,
  output logic [PARALLELISM-1:0]         div_dividend,
  output logic [PARALLELISM-1:0]         div_divisor,
  input  logic [PARALLELISM-1:0]         div_quotient,
  input  logic [PARALLELISM-1:0]         div_reminder,
  input  logic                           div_res_ready,
  output logic                           busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CW    = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                   state_r;
  logic [PTR_W-1:0]         rr_ptr_r;
  logic [PTR_W-1:0]         owner_r;
  logic                     res_ready_q;
  logic                     usigned_r;
  logic [PARALLELISM-1:0]   dividend_r;
  logic [PARALLELISM-1:0]   divisor_r;
  logic [PARALLELISM-1:0]   quot_r;
  logic [PARALLELISM-1:0]   rem_r;
  logic                     div_valid_r;
  logic                     busy_r;
  logic [NUM_REQ-1:0]       resp_valid_r;

  logic [PTR_W-1:0]         grant_idx_s;
  logic                     grant_found_s;
  logic                     grant_ok_s;
  logic                     completion_s;
  logic [NUM_REQ-1:0]       req_ready_s;
  logic [PTR_W-1:0]         rr_next_s;
  logic                     sel_usigned_s;
  logic [PARALLELISM-1:0]   sel_dividend_s;
  logic [PARALLELISM-1:0]   sel_divisor_s;
  logic [PARALLELISM-1:0]   dividend_a [NUM_REQ];
  logic [PARALLELISM-1:0]   divisor_a  [NUM_REQ];

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign dividend_a[g] = req_dividend[g*PARALLELISM +: PARALLELISM];
    assign divisor_a[g]  = req_divisor[g*PARALLELISM +: PARALLELISM];
  end

  // Round-robin search from rr_ptr_r upward with wrap; first valid requester wins.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [CW-1:0] cand_v;
      cand_v = {1'b0, rr_ptr_r} + CW'(k);
      if (cand_v >= CW'(NUM_REQ)) begin
        cand_v = cand_v - CW'(NUM_REQ);
      end else begin
        cand_v = cand_v;
      end
      if (!grant_found_s && req_valid[cand_v[PTR_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_v[PTR_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Grants are withheld while the divider still shows a stale res_ready level.
  always_comb begin
    grant_ok_s     = (state_r == IDLE) && !div_res_ready && grant_found_s;
    req_ready_s    = '0;
    sel_usigned_s  = req_usigned[grant_idx_s];
    sel_dividend_s = dividend_a[grant_idx_s];
    sel_divisor_s  = divisor_a[grant_idx_s];
    completion_s   = div_res_ready & ~res_ready_q;
    if (grant_ok_s) begin
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
    if (owner_r == PTR_W'(NUM_REQ - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = owner_r + PTR_W'(1);
    end
  end

  // Controller FSM; all handshake outputs except req_ready are registered here.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r      <= IDLE;
      rr_ptr_r     <= '0;
      owner_r      <= '0;
      res_ready_q  <= 1'b0;
      usigned_r    <= 1'b0;
      dividend_r   <= '0;
      divisor_r    <= '0;
      quot_r       <= '0;
      rem_r        <= '0;
      div_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      resp_valid_r <= '0;
    end else begin
      res_ready_q <= div_res_ready;
      case (state_r)
        IDLE: begin
          if (grant_ok_s) begin
            usigned_r  <= sel_usigned_s;
            dividend_r <= sel_dividend_s;
            divisor_r  <= sel_divisor_s;
            owner_r    <= grant_idx_s;
            busy_r     <= 1'b1;
            if (sel_divisor_s != {PARALLELISM{1'b0}}) begin
              state_r     <= ISSUE;
              div_valid_r <= 1'b1;
            end else begin
              // Divide-by-zero answered locally: all-ones quotient, dividend as remainder.
              state_r      <= RESP;
              quot_r       <= {PARALLELISM{1'b1}};
              rem_r        <= sel_dividend_s;
              resp_valid_r <= onehot(grant_idx_s);
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          div_valid_r <= 1'b0;
          state_r     <= WAIT;
        end
        WAIT: begin
          if (completion_s) begin
            quot_r       <= div_quotient;
            rem_r        <= div_reminder;
            resp_valid_r <= onehot(owner_r);
            state_r      <= RESP;
          end else begin
            state_r <= WAIT;
          end
        end
        RESP: begin
          if (resp_ready[owner_r]) begin
            resp_valid_r <= '0;
            busy_r       <= 1'b0;
            rr_ptr_r     <= rr_next_s;
            state_r      <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r      <= IDLE;
          div_valid_r  <= 1'b0;
          busy_r       <= 1'b0;
          resp_valid_r <= '0;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_s;
  assign resp_valid    = resp_valid_r;
  assign resp_quotient = quot_r;
  assign resp_reminder = rem_r;
  assign div_valid     = div_valid_r;
  assign div_usigned   = usigned_r;
  assign div_dividend  = dividend_r;
  assign div_divisor   = divisor_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a behavioural DivisorUnit (4-cycle latency).
module tb_div_share_arbiter;

  localparam int P       = 32;
  localparam int N       = 2;
  localparam int DIV_LAT = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_usigned = '0;
  logic [N*P-1:0] req_dividend = '0;
  logic [N*P-1:0] req_divisor = '0;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready = '0;
  logic [P-1:0]   resp_quotient;
  logic [P-1:0]   resp_reminder;
  logic           div_valid;
  logic           div_usigned;
  logic [P-1:0]   div_dividend;
  logic [P-1:0]   div_divisor;
  logic [P-1:0]   div_quotient = '0;
  logic [P-1:0]   div_reminder = '0;
  logic           div_res_ready = 1'b0;
  logic           busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int dv_cnt  = 0;
  int m_cnt   = 0;
  int m_hold  = 0;

  div_share_arbiter #(.PARALLELISM(P), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_usigned(req_usigned),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quotient(resp_quotient), .resp_reminder(resp_reminder),
    .div_valid(div_valid), .div_usigned(div_usigned),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_reminder(div_reminder),
    .div_res_ready(div_res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Divider model: res_ready rises DIV_LAT cycles after the valid cycle, stays high two cycles.
  always @(posedge clk) begin
    if (div_valid) begin
      dv_cnt <= dv_cnt + 1;
      m_cnt  <= DIV_LAT - 1;
      if (div_usigned) begin
        div_quotient <= div_dividend / div_divisor;
        div_reminder <= div_dividend % div_divisor;
      end else begin
        div_quotient <= $signed(div_dividend) / $signed(div_divisor);
        div_reminder <= $signed(div_dividend) % $signed(div_divisor);
      end
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        div_res_ready <= 1'b1;
        m_hold        <= 2;
      end
    end else if (m_hold != 0) begin
      m_hold <= m_hold - 1;
      if (m_hold == 1) div_res_ready <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic us, input logic [P-1:0] a, input logic [P-1:0] b);
    req_usigned[r]          = us;
    req_dividend[r*P +: P]  = a;
    req_divisor[r*P +: P]   = b;
  endtask

  task automatic run_op(input string tag, input int r, input logic us,
                        input logic [P-1:0] a, input logic [P-1:0] b,
                        input logic [P-1:0] qe, input logic [P-1:0] re, input int lat_exp);
    int n;
    int dv0;
    logic [N-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    @(negedge clk);
    set_req(r, us, a, b);
    req_valid[r] = 1'b1;
    #1;
    chk({tag, "_grant"}, req_ready, oh);
    dv0 = dv_cnt;
    @(negedge clk);
    req_valid[r] = 1'b0;
    n = 1;
    while (resp_valid == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, lat_exp);
    chk({tag, "_owner"}, resp_valid, oh);
    chk({tag, "_quot"}, resp_quotient, qe);
    chk({tag, "_rem"}, resp_reminder, re);
    chk({tag, "_div_pulses"}, dv_cnt - dv0, (lat_exp == 1) ? 0 : 1);
    resp_ready[r] = 1'b1;
    @(negedge clk);
    resp_ready[r] = 1'b0;
    #1;
    chk({tag, "_busy_done"}, busy, 1'b0);
  endtask

  initial begin
    int k;
    logic [N-1:0] oh;
    logic [N-1:0] seen;

    // Reset values while reset is held
    @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, '0);
    chk("rst_resp_valid", resp_valid, '0);
    chk("rst_div_valid", div_valid, 1'b0);
    chk("rst_div_dividend", div_dividend, '0);
    chk("rst_resp_quot", resp_quotient, '0);
    @(negedge clk);
    rst_n = 1'b0;

    // Round robin with both requesters continuously valid from reset
    set_req(0, 1'b1, 32'd100, 32'd7);
    set_req(1, 1'b1, 32'd50, 32'd5);
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      oh = (i % 2 == 0) ? 2'b01 : 2'b10;
      k = 0;
      while (req_ready == '0 && k < 20) begin
        @(negedge clk);
        #1;
        k++;
      end
      chk("rr_grant", req_ready, oh);
      @(negedge clk);
      k = 0;
      while (resp_valid == '0 && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("rr_owner", resp_valid, oh);
      chk("rr_quot", resp_quotient, (i % 2 == 0) ? 32'd14 : 32'd10);
      resp_ready = oh;
      @(negedge clk);
      resp_ready = '0;
      #1;
    end
    req_valid = '0;

    run_op("unsigned", 0, 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 6);
    run_op("signed", 1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 6);
    run_op("divzero_u", 0, 1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1);
    run_op("divzero_s", 1, 1'b0, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 1);

    // Backpressure: owner 0 holds resp_ready low, requester 1 waits
    @(negedge clk);
    set_req(0, 1'b1, 32'd1000, 32'd10);
    set_req(1, 1'b1, 32'd81, 32'd9);
    req_valid = 2'b11;
    #1;
    chk("bp_grant0", req_ready, 2'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
    k = 0;
    while (resp_valid == '0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("bp_owner0", resp_valid, 2'b01);
    resp_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("bp_quot_hold", resp_quotient, 32'd100);
      chk("bp_no_grant", req_ready, 2'b00);
      chk("bp_valid_hold", resp_valid, 2'b01);
    end
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = '0;
    #1;
    chk("bp_grant1", req_ready, 2'b10);
    @(negedge clk);
    req_valid[1] = 1'b0;
    k = 0;
    while (resp_valid == '0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("bp_owner1", resp_valid, 2'b10);
    chk("bp_quot1", resp_quotient, 32'd9);
    resp_ready = 2'b10;
    @(negedge clk);
    resp_ready = '0;

    // Reset while the divider is running
    @(negedge clk);
    set_req(0, 1'b1, 32'd100, 32'd7);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_div_valid", div_valid, 1'b0);
    chk("arst_div_dividend", div_dividend, '0);
    chk("arst_div_divisor", div_divisor, '0);
    chk("arst_resp_valid", resp_valid, '0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    req_valid = 2'b01;
    #1;
    chk("arst_gate_hi", req_ready, 2'b00);
    @(negedge clk);
    #1;
    chk("arst_gate_hi2", req_ready, 2'b00);
    req_valid = '0;
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    chk("arst_no_resp", seen, 2'b00);
    chk("arst_idle", busy, 1'b0);

    run_op("post_rst", 1, 1'b0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
